// File: rtl/select_pkg.sv
// Shared types and helpers for select_pipe: width extension of channel data and
// the select-mode enumeration. Optional feature macro: SELECT_PIPE_RR_EN.
package select_pkg;

  typedef enum logic {
    SEL_DIRECT,
    SEL_RR
  } sel_mode_e;

  // Extends the low in_w bits of data to 32 bits; callers truncate to their output width.
  function automatic logic [31:0] sel_extend(input logic [31:0] data,
                                             input int unsigned in_w,
                                             input logic        is_signed);
    logic signed [31:0] shifted;
    shifted = $signed(data << (32 - in_w));
    if (is_signed) begin
      return 32'(shifted >>> (32 - in_w));
    end
    return data;
  endfunction

endpackage

// File: rtl/select_rr_arb.sv
// Rotating-priority arbiter: grants the first requesting index strictly after ptr,
// wrapping N-1 -> 0.
module select_rr_arb #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] index,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SEL_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/select_pipe.sv
// N-channel valid/ready selector with a one-deep registered output stage.
// Define SELECT_PIPE_RR_EN to add the rr_mode port and round-robin arbitration.
module select_pipe
  import select_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  IN_W        = 4,
  parameter int                  OUT_W       = 5,
  parameter logic [CHANNELS-1:0] SIGNED_MASK = CHANNELS'(4'b1100),
  localparam int                 SEL_W       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel_in,
`ifdef SELECT_PIPE_RR_EN
  input  logic                      rr_mode,
`endif
  output logic signed [OUT_W-1:0]   out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  logic [OUT_W-1:0]    ext_word [CHANNELS];
  logic [CHANNELS-1:0] dir_grant;
  logic [CHANNELS-1:0] grant_vec;
  logic [SEL_W-1:0]    grant_idx;
  logic                sel_ok;
  logic                err_set;
  logic                load;
  logic                xfer;

  assign sel_ok = ({1'b0, sel_in} < (SEL_W + 1)'(CHANNELS));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign ext_word[gi]  = OUT_W'(sel_extend(32'(in_data[gi*IN_W +: IN_W]), IN_W,
                                               SIGNED_MASK[gi]));
      assign dir_grant[gi] = sel_ok & (sel_in == SEL_W'(gi));
    end
  endgenerate

`ifdef SELECT_PIPE_RR_EN
  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] arb_grant;
  logic [SEL_W-1:0]    arb_index;
  logic                arb_any;

  select_rr_arb #(
    .N    (CHANNELS),
    .SEL_W(SEL_W)
  ) u_arb (
    .req  (in_valid),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .index(arb_index),
    .any  (arb_any)
  );

  assign grant_vec = rr_mode ? arb_grant : dir_grant;
  assign grant_idx = rr_mode ? arb_index : sel_in;
  assign err_set   = !rr_mode && !sel_ok && (|in_valid);

  // Pointer only moves on an actual round-robin transfer, never on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SEL_W'(CHANNELS - 1);
    end else if (rr_mode && xfer) begin
      rr_ptr <= arb_index;
    end
  end
`else
  assign grant_vec = dir_grant;
  assign grant_idx = sel_in;
  assign err_set   = !sel_ok && (|in_valid);
`endif

  assign load     = !out_valid || out_ready;
  // rst_n gates ready so nothing is handshaken while reset is held.
  assign in_ready = {CHANNELS{load && rst_n}} & grant_vec;
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= ext_word[grant_idx];
        out_chan <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (err_set) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_select_pipe.sv
// Randomized and directed bench for select_pipe against a behavioural model;
// also drives a 3-channel instance for the out-of-range select path.
module tb_select_pipe;
  import select_pkg::*;

  localparam int         CH   = 4;
  localparam logic [3:0] MASK = 4'b1100;

  logic              clk;
  logic              rst_n;
  logic [15:0]       in_data;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [1:0]        sel_in;
  logic              rr_mode;
  logic signed [4:0] out_data;
  logic [1:0]        out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;

  logic [11:0]       in_data3;
  logic [2:0]        in_valid3;
  logic [2:0]        in_ready3;
  logic [1:0]        sel3;
  logic signed [4:0] out_data3;
  logic [1:0]        out_chan3;
  logic              out_valid3;
  logic              sel_err3;

  sel_mode_e mode;
  int checks;
  int failures;

  // Behavioural model state
  logic       m_valid;
  logic [4:0] m_data;
  logic [1:0] m_chan;
  logic       m_err;
  int         m_ptr;

  select_pipe #(.CHANNELS(4), .IN_W(4), .OUT_W(5), .SIGNED_MASK(4'b1100)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_in(sel_in),
`ifdef SELECT_PIPE_RR_EN
    .rr_mode(rr_mode),
`endif
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  select_pipe #(.CHANNELS(3), .IN_W(4), .OUT_W(5), .SIGNED_MASK(3'b100)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel_in(sel3),
`ifdef SELECT_PIPE_RR_EN
    .rr_mode(1'b0),
`endif
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(1'b1), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_ext(input int ch, input logic [3:0] d);
    int v;
    v = int'(d);
    if (MASK[ch] && v >= 8) v -= 16;
    return 5'(v);
  endfunction

  // One clock: compare against the model at the falling edge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic step();
    int         g;
    int         c;
    logic       load;
    logic [3:0] exp_rdy;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_data", {27'd0, $unsigned(out_data)}, 0);
      chk("rst_out_chan", {30'd0, out_chan}, 0);
      chk("rst_sel_err", {31'd0, sel_err}, 0);
      chk("rst_in_ready", {28'd0, in_ready}, 0);
      m_valid = 1'b0; m_data = '0; m_chan = '0; m_err = 1'b0; m_ptr = CH - 1;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_data", {27'd0, $unsigned(out_data)}, {27'd0, m_data});
      chk("out_chan", {30'd0, out_chan}, {30'd0, m_chan});
      chk("sel_err", {31'd0, sel_err}, {31'd0, m_err});
      g = -1;
      if (mode == SEL_RR) begin
        for (int k = 1; k <= CH; k++) begin
          c = (m_ptr + k) % CH;
          if (g < 0 && in_valid[c]) g = c;
        end
      end else if (int'(sel_in) < CH) begin
        g = int'(sel_in);
      end else if (|in_valid) begin
        m_err = 1'b1;
      end
      load    = !m_valid || out_ready;
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'd0;
      chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
      if (load) begin
        m_valid = (g >= 0) && in_valid[g];
        if (m_valid) begin
          m_data = m_ext(g, in_data[g*4 +: 4]);
          m_chan = 2'(g);
          if (mode == SEL_RR) m_ptr = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 0);
    chk("async_in_ready", {28'd0, in_ready}, 0);
    chk("async_sel_err3", {31'd0, sel_err3}, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    mode = SEL_DIRECT; rr_mode = 1'b0;
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel_in = '0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0; sel3 = '0;
    m_valid = 1'b0; m_data = '0; m_chan = '0; m_err = 1'b0; m_ptr = CH - 1;
    step();
    step();
    rst_n = 1'b1;

    // Hand-computed extension results
    sel_in = 2'd0; in_valid = 4'b0001; in_data = 16'h000F;
    step();
    chk("lit_u0_data", {27'd0, $unsigned(out_data)}, 32'b01111);
    chk("lit_u0_chan", {30'd0, out_chan}, 0);
    chk("lit_u0_valid", {31'd0, out_valid}, 1);
    sel_in = 2'd2; in_valid = 4'b0100; in_data = 16'h0800;
    step();
    chk("lit_s2_data", {27'd0, $unsigned(out_data)}, 32'b11000);
    chk("lit_s2_chan", {30'd0, out_chan}, 2);
    sel_in = 2'd3; in_valid = 4'b1000; in_data = 16'h7000;
    step();
    chk("lit_s3_data", {27'd0, $unsigned(out_data)}, 32'b00111);

    // Stall: output held, nothing accepted
    out_ready = 1'b0; sel_in = 2'd1; in_valid = 4'b1111; in_data = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_stall_ready", {28'd0, in_ready}, 0);
      step();
      chk("lit_stall_data", {27'd0, $unsigned(out_data)}, 32'b00111);
      chk("lit_stall_valid", {31'd0, out_valid}, 1);
    end
    out_ready = 1'b1; sel_in = 2'd1; in_valid = 4'b0010; in_data = 16'h0050;
    step();
    chk("lit_b2b1_data", {27'd0, $unsigned(out_data)}, 32'b00101);
    chk("lit_b2b1_chan", {30'd0, out_chan}, 1);
    sel_in = 2'd0; in_valid = 4'b0001; in_data = 16'h0009;
    step();
    chk("lit_b2b2_data", {27'd0, $unsigned(out_data)}, 32'b01001);
    chk("lit_b2b2_valid", {31'd0, out_valid}, 1);

    // Three-channel instance: out-of-range select
    in_valid = '0;
    chk("lit_err3_init", {31'd0, sel_err3}, 0);
    sel3 = 2'd1; in_valid3 = 3'b010; in_data3 = 12'h030;
    #1;
    chk("lit_rdy3_sel1", {29'd0, in_ready3}, 32'b010);
    sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    chk("lit_rdy3_sel3", {29'd0, in_ready3}, 0);
    step();
    chk("lit_err3_set", {31'd0, sel_err3}, 1);
    sel3 = 2'd0; in_valid3 = '0;
    step();
    chk("lit_err3_sticky", {31'd0, sel_err3}, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
`ifdef SELECT_PIPE_RR_EN
      if ($urandom_range(0, 15) == 0) mode = (mode == SEL_RR) ? SEL_DIRECT : SEL_RR;
      rr_mode = (mode == SEL_RR);
`endif
      in_data   = 16'($urandom);
      in_valid  = 4'($urandom);
      sel_in    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset mid-stream
    mode = SEL_DIRECT; rr_mode = 1'b0;
    in_valid = 4'b1111; out_ready = 1'b1; sel_in = 2'd2;
    step();
    async_reset();

`ifdef SELECT_PIPE_RR_EN
    mode = SEL_RR; rr_mode = 1'b1; in_valid = 4'b1011; out_ready = 1'b1; in_data = 16'h1234;
    step();
    chk("lit_rr_pre0", {30'd0, out_chan}, 0);
    step();
    chk("lit_rr_pre1", {30'd0, out_chan}, 1);
    async_reset();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] seq_v [3];
      seq_v[0] = 2'd0; seq_v[1] = 2'd1; seq_v[2] = 2'd3;
      step();
      chk("lit_rr_seq", {30'd0, out_chan}, {30'd0, seq_v[i % 3]});
    end
`endif

    in_valid = '0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
